// File: rtl/mips_mem_arbiter_pkg.sv
// ============================================================================
// mips_mem_arb_pkg : shared types for the CPU/debug memory arbiter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } arb_state_t;

   typedef enum logic {
      GRANT_CPU = 1'b0,
      GRANT_DBG = 1'b1
   } grant_t;

   // Wide enough for the largest legal WAIT_CYCLES (15).
   localparam int CNT_W = 4;

   function automatic grant_t other_grant(input grant_t g);
      return (g == GRANT_CPU) ? GRANT_DBG : GRANT_CPU;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mips_mem_arbiter_rr_arbiter2.sv
// ============================================================================
// rr_arbiter2 : combinational two-way round-robin pick (CPU vs DBG)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2
   import mips_mem_arb_pkg::*;
(
   input  logic   cpu_req,
   input  logic   dbg_req,
   input  grant_t last_grant,
   output grant_t grant,
   output logic   valid
);

   always_comb begin
      valid = cpu_req | dbg_req;
      grant = GRANT_CPU;
      // On a tie the side that did not win last time goes next.
      if (cpu_req && dbg_req) begin
         grant = other_grant(last_grant);
      end else if (dbg_req) begin
         grant = GRANT_DBG;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mips_mem_arbiter.sv
// ============================================================================
// mips_mem_arbiter : shares one byte-wide single-port memory between the
// multicycle MIPS core and the program-load/debug port. Rev 1.0
// ============================================================================
`default_nettype none

module mips_mem_arbiter
   import mips_mem_arb_pkg::*;
#(
   parameter int AWIDTH      = 8,
   parameter int DWIDTH      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [AWIDTH-1:0] cpu_adr,
   input  logic [DWIDTH-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DWIDTH-1:0] cpu_rdata,

   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [AWIDTH-1:0] dbg_adr,
   input  logic [DWIDTH-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic [DWIDTH-1:0] dbg_rdata,

   output logic              mem_cs,
   output logic              mem_we,
   output logic [AWIDTH-1:0] mem_adr,
   output logic [DWIDTH-1:0] mem_wdata,
   input  logic [DWIDTH-1:0] mem_rdata,

   output logic              busy,
   output logic              grant_dbg
);

   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   arb_state_t        state_q,     state_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   grant_t            last_grant_q, last_grant_d;
   logic              mem_cs_q,    mem_cs_d;
   logic              mem_we_q,    mem_we_d;
   logic [AWIDTH-1:0] mem_adr_q,   mem_adr_d;
   logic [DWIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic              cpu_ack_q,   cpu_ack_d;
   logic              dbg_ack_q,   dbg_ack_d;
   logic [DWIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DWIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
   logic              busy_q,      busy_d;

   grant_t arb_grant;
   logic   arb_valid;

   rr_arbiter2 u_rr_arbiter2 (
      .cpu_req    (cpu_req),
      .dbg_req    (dbg_req),
      .last_grant (last_grant_q),
      .grant      (arb_grant),
      .valid      (arb_valid)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      mem_cs_d     = mem_cs_q;
      mem_we_d     = mem_we_q;
      mem_adr_d    = mem_adr_q;
      mem_wdata_d  = mem_wdata_q;
      cpu_ack_d    = 1'b0;
      dbg_ack_d    = 1'b0;
      cpu_rdata_d  = cpu_rdata_q;
      dbg_rdata_d  = dbg_rdata_q;

      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               last_grant_d = arb_grant;
               mem_cs_d     = 1'b1;
               cnt_d        = WAIT_LOAD;
               state_d      = ACCESS;
               if (arb_grant == GRANT_DBG) begin
                  mem_we_d    = dbg_we;
                  mem_adr_d   = dbg_adr;
                  mem_wdata_d = dbg_wdata;
               end else begin
                  mem_we_d    = cpu_we;
                  mem_adr_d   = cpu_adr;
                  mem_wdata_d = cpu_wdata;
               end
            end
         end

         ACCESS: begin
            // last_grant_q names the current winner for the whole transaction.
            if (cnt_q == '0) begin
               if (!mem_we_q) begin
                  if (last_grant_q == GRANT_DBG) begin
                     dbg_rdata_d = mem_rdata;
                  end else begin
                     cpu_rdata_d = mem_rdata;
                  end
               end
               mem_cs_d = 1'b0;
               mem_we_d = 1'b0;
               if (last_grant_q == GRANT_DBG) begin
                  dbg_ack_d = 1'b1;
               end else begin
                  cpu_ack_d = 1'b1;
               end
               state_d = ACK;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         ACK: begin
            state_d = IDLE;
         end

         default: begin
            state_d  = IDLE;
            mem_cs_d = 1'b0;
            mem_we_d = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         last_grant_q <= GRANT_DBG;
         mem_cs_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_adr_q    <= '0;
         mem_wdata_q  <= '0;
         cpu_ack_q    <= 1'b0;
         dbg_ack_q    <= 1'b0;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         mem_cs_q     <= mem_cs_d;
         mem_we_q     <= mem_we_d;
         mem_adr_q    <= mem_adr_d;
         mem_wdata_q  <= mem_wdata_d;
         cpu_ack_q    <= cpu_ack_d;
         dbg_ack_q    <= dbg_ack_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
         busy_q       <= busy_d;
      end
   end

   assign cpu_ack   = cpu_ack_q;
   assign dbg_ack   = dbg_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dbg_rdata = dbg_rdata_q;
   assign mem_cs    = mem_cs_q;
   assign mem_we    = mem_we_q;
   assign mem_adr   = mem_adr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign grant_dbg = (last_grant_q == GRANT_DBG);

endmodule

`default_nettype wire

// File: tb/tb_mips_mem_arbiter.sv
// ============================================================================
// tb_mips_mem_arbiter : randomized + directed bench for mips_mem_arbiter
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mips_mem_arbiter;

   localparam int W = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // Main DUT (WAIT_CYCLES = 2)
   logic       cpu_req = 1'b0, cpu_we = 1'b0;
   logic [7:0] cpu_adr = '0, cpu_wdata = '0;
   logic       dbg_req = 1'b0, dbg_we = 1'b0;
   logic [7:0] dbg_adr = '0, dbg_wdata = '0;
   logic       cpu_ack, dbg_ack, mem_cs, mem_we, busy, grant_dbg;
   logic [7:0] cpu_rdata, dbg_rdata, mem_adr, mem_wdata, mem_rdata;

   // Second DUT (WAIT_CYCLES = 1), CPU side only
   logic       c1_req = 1'b0, c1_we = 1'b0;
   logic [7:0] c1_adr = '0, c1_wdata = '0;
   logic       c1_ack, c1_dbg_ack, c1_mem_cs, c1_mem_we, c1_busy, c1_grant_dbg;
   logic [7:0] c1_rdata, c1_dbg_rdata, c1_mem_adr, c1_mem_wdata, c1_mem_rdata;

   mips_mem_arbiter #(.AWIDTH(8), .DWIDTH(8), .WAIT_CYCLES(W)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .grant_dbg(grant_dbg)
   );

   mips_mem_arbiter #(.AWIDTH(8), .DWIDTH(8), .WAIT_CYCLES(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .cpu_req(c1_req), .cpu_we(c1_we), .cpu_adr(c1_adr), .cpu_wdata(c1_wdata),
      .cpu_ack(c1_ack), .cpu_rdata(c1_rdata),
      .dbg_req(1'b0), .dbg_we(1'b0), .dbg_adr(8'h00), .dbg_wdata(8'h00),
      .dbg_ack(c1_dbg_ack), .dbg_rdata(c1_dbg_rdata),
      .mem_cs(c1_mem_cs), .mem_we(c1_mem_we), .mem_adr(c1_mem_adr), .mem_wdata(c1_mem_wdata),
      .mem_rdata(c1_mem_rdata), .busy(c1_busy), .grant_dbg(c1_grant_dbg)
   );

   function automatic logic [7:0] init_val(input int i);
      return 8'(i) ^ 8'hB5;
   endfunction

   // Memory devices: asynchronous read, write on the clock edge while selected.
   logic [7:0] ram  [256];
   logic [7:0] ram1 [256];
   logic       ram_ready = 1'b0;
   assign mem_rdata    = ram[mem_adr];
   assign c1_mem_rdata = ram1[c1_mem_adr];

   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < 256; i++) begin
            ram[i]  <= init_val(i);
            ram1[i] <= init_val(i);
         end
         ram_ready <= 1'b1;
      end else begin
         if (mem_cs && mem_we)       ram[mem_adr]     <= mem_wdata;
         if (c1_mem_cs && c1_mem_we) ram1[c1_mem_adr] <= c1_mem_wdata;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: a transaction granted from IDLE cycle m_t owns
   // cycles m_t+1..m_t+W (select) and m_t+W+1 (ack).
   int         cyc = 0;
   logic       mon_en = 1'b0, ref_ready = 1'b0;
   logic       m_active = 1'b0, m_lastdbg = 1'b1, m_dbg = 1'b0, m_we = 1'b0;
   int         m_t = 0;
   logic [7:0] m_adr = '0, m_wd = '0, m_rd = '0, exp_cpu_rd = '0, exp_dbg_rd = '0;
   logic [7:0] ref_mem [256];
   logic       w_pick_dbg, w_acc, w_ack;

   assign w_pick_dbg = dbg_req && (!cpu_req || !m_lastdbg);
   assign w_acc      = m_active && (cyc >= m_t + 1) && (cyc <= m_t + W);
   assign w_ack      = m_active && (cyc == m_t + W + 1);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!ref_ready) begin
         for (int i = 0; i < 256; i++) ref_mem[i] <= init_val(i);
         ref_ready <= 1'b1;
      end
      if (reset) begin
         mon_en     <= 1'b1;
         m_active   <= 1'b0;
         m_lastdbg  <= 1'b1;
         exp_cpu_rd <= '0;
         exp_dbg_rd <= '0;
      end else begin
         if (m_active && cyc == m_t + W && !m_we) begin
            if (m_dbg) exp_dbg_rd <= m_rd;
            else       exp_cpu_rd <= m_rd;
         end
         if ((!m_active || cyc > m_t + W + 1) && (cpu_req || dbg_req)) begin
            m_active  <= 1'b1;
            m_t       <= cyc;
            m_dbg     <= w_pick_dbg;
            m_lastdbg <= w_pick_dbg;
            m_we      <= w_pick_dbg ? dbg_we    : cpu_we;
            m_adr     <= w_pick_dbg ? dbg_adr   : cpu_adr;
            m_wd      <= w_pick_dbg ? dbg_wdata : cpu_wdata;
            m_rd      <= ref_mem[w_pick_dbg ? dbg_adr : cpu_adr];
            if (w_pick_dbg ? dbg_we : cpu_we)
               ref_mem[w_pick_dbg ? dbg_adr : cpu_adr] <= w_pick_dbg ? dbg_wdata : cpu_wdata;
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("busy",      busy,      w_acc || w_ack);
         chk("mem_cs",    mem_cs,    w_acc);
         chk("mem_we",    mem_we,    w_acc && m_we);
         chk("cpu_ack",   cpu_ack,   w_ack && !m_dbg);
         chk("dbg_ack",   dbg_ack,   w_ack && m_dbg);
         chk("cpu_rdata", cpu_rdata, exp_cpu_rd);
         chk("dbg_rdata", dbg_rdata, exp_dbg_rd);
         chk("grant_dbg", grant_dbg, m_lastdbg);
         if (w_acc) begin
            chk("mem_adr", mem_adr, m_adr);
            if (m_we) chk("mem_wdata", mem_wdata, m_wd);
         end
      end
   end

   task automatic cpu_txn(input logic we, input logic [7:0] adr, input logic [7:0] wd);
      int n;
      cpu_we = we; cpu_adr = adr; cpu_wdata = wd; cpu_req = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!cpu_ack && n < 40);
      chk("cpu_ack_wait", cpu_ack, 1'b1);
      @(posedge clk); #1;
      cpu_req = 1'b0;
   endtask

   task automatic dbg_txn(input logic we, input logic [7:0] adr, input logic [7:0] wd);
      int n;
      dbg_we = we; dbg_adr = adr; dbg_wdata = wd; dbg_req = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!dbg_ack && n < 40);
      chk("dbg_ack_wait", dbg_ack, 1'b1);
      @(posedge clk); #1;
      dbg_req = 1'b0;
   endtask

   int   ack_cyc [4];
   logic ack_dbg [4];
   logic ack_gd  [4];
   int   na, n, a1, a2;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",      busy,      1'b0);
      chk("rst_mem_cs",    mem_cs,    1'b0);
      chk("rst_mem_we",    mem_we,    1'b0);
      chk("rst_mem_adr",   mem_adr,   8'h00);
      chk("rst_mem_wdata", mem_wdata, 8'h00);
      chk("rst_acks",      {cpu_ack, dbg_ack}, 2'b00);
      chk("rst_rdata",     {cpu_rdata, dbg_rdata}, 16'h0000);
      chk("rst_grant_dbg", grant_dbg, 1'b1);

      // CPU read of 0x10: select for two cycles, then a single ack with data.
      reset = 1'b0;
      cpu_we = 1'b0; cpu_adr = 8'h10; cpu_req = 1'b1;
      @(negedge clk); chk("t1_idle_cs", mem_cs, 1'b0);
      @(negedge clk); chk("t1_cs_a", mem_cs, 1'b1); chk("t1_adr_a", mem_adr, 8'h10);
      @(negedge clk); chk("t1_cs_b", mem_cs, 1'b1); chk("t1_adr_b", mem_adr, 8'h10);
      @(negedge clk);
      chk("t1_ack", cpu_ack, 1'b1); chk("t1_rdata", cpu_rdata, 8'hA5);
      chk("t1_dbg_ack", dbg_ack, 1'b0); chk("t1_cs_off", mem_cs, 1'b0);
      @(posedge clk); #1; cpu_req = 1'b0;
      @(negedge clk); chk("t1_ack_once", cpu_ack, 1'b0);
      @(posedge clk); #1;

      // DBG write 0x3F <= 0x5C.
      dbg_we = 1'b1; dbg_adr = 8'h3F; dbg_wdata = 8'h5C; dbg_req = 1'b1;
      @(negedge clk);
      @(negedge clk); chk("t2_we_a", mem_we, 1'b1);
      @(negedge clk); chk("t2_we_b", mem_we, 1'b1);
      @(negedge clk); chk("t2_ack", dbg_ack, 1'b1); chk("t2_cpu_ack", cpu_ack, 1'b0);
      @(posedge clk); #1; dbg_req = 1'b0; dbg_we = 1'b0;
      @(posedge clk); #1;
      chk("t2_mem", ram[8'h3F], 8'h5C);
      chk("t2_cpu_rdata", cpu_rdata, 8'hA5);
      chk("t2_dbg_rdata", dbg_rdata, 8'h00);

      // Both requesters held high from reset release.
      reset = 1'b1;
      cpu_we = 1'b0; cpu_adr = 8'h05; cpu_req = 1'b1;
      dbg_we = 1'b0; dbg_adr = 8'h06; dbg_req = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b0;
      na = 0;
      for (int k = 0; k < 60 && na < 4; k++) begin
         @(negedge clk);
         if (cpu_ack || dbg_ack) begin
            ack_cyc[na] = cyc; ack_dbg[na] = dbg_ack; ack_gd[na] = grant_dbg;
            na++;
         end
      end
      chk("t3_nacks", na, 4);
      for (int k = 0; k < 4; k++) begin
         chk("t3_order", ack_dbg[k], k % 2);
         chk("t3_grant_dbg", ack_gd[k], k % 2);
         if (k > 0) chk("t3_spacing", ack_cyc[k] - ack_cyc[k-1], W + 2);
      end
      @(posedge clk); #1; cpu_req = 1'b0; dbg_req = 1'b0;
      @(posedge clk); #1;

      // Reset in the second select cycle of a CPU write, then reissue.
      cpu_we = 1'b1; cpu_adr = 8'h44; cpu_wdata = 8'h77; cpu_req = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1; reset = 1'b1; cpu_req = 1'b0;
      @(posedge clk); #1; reset = 1'b0;
      chk("t4_cs", mem_cs, 1'b0); chk("t4_ack", cpu_ack, 1'b0); chk("t4_busy", busy, 1'b0);
      @(negedge clk); chk("t4_ack_n", cpu_ack, 1'b0);
      @(posedge clk); #1;
      cpu_txn(1'b1, 8'h44, 8'h77);
      chk("t4_mem", ram[8'h44], 8'h77);

      // WAIT_CYCLES=1 back-to-back reads.
      c1_we = 1'b0; c1_adr = 8'h00; c1_req = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!c1_ack && n < 20);
      chk("t5_ack1", c1_ack, 1'b1); chk("t5_data1", c1_rdata, 8'hB5);
      a1 = cyc;
      @(posedge clk); #1; c1_adr = 8'h01;
      n = 0;
      do begin @(negedge clk); n++; end while (!c1_ack && n < 20);
      chk("t5_ack2", c1_ack, 1'b1); chk("t5_data2", c1_rdata, 8'hB4);
      a2 = cyc;
      chk("t5_spacing", a2 - a1, 3);
      @(posedge clk); #1; c1_req = 1'b0;

      // DBG address changes mid-access; latched address must hold.
      dbg_we = 1'b0; dbg_adr = 8'h20; dbg_req = 1'b1;
      @(posedge clk); #1; dbg_adr = 8'h21; chk("t6_adr_a", mem_adr, 8'h20);
      @(posedge clk); #1; chk("t6_adr_b", mem_adr, 8'h20);
      @(posedge clk); #1; chk("t6_ack", dbg_ack, 1'b1); chk("t6_rdata", dbg_rdata, 8'h95);
      dbg_req = 1'b0;
      @(posedge clk); #1;

      // Randomized concurrent traffic, checked by the model every cycle.
      fork
         for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            cpu_txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
         end
         for (int j = 0; j < 30; j++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            dbg_txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
         end
      join
      repeat (5) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Shares one single-port byte-wide external memory between two requesters:
  - the multicycle 8-bit MIPS core's memory port (CPU side);
  - a program-load/debug port (DBG side) used to load code and inspect data.
- Sits between the core wrapper and the user IO pins.
- Arbitrates round-robin, sequences a fixed-latency memory access and returns a one-cycle acknowledge to the winner.
- The CPU wrapper stalls the core until cpu_ack.

Parameters:
- AWIDTH, 8, address width.
- DWIDTH, 8, data width.
- WAIT_CYCLES, 2, cycles mem_cs is held per access (legal range 1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU request; held with cpu_we/adr/wdata stable until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_adr  in  AWIDTH  CPU address.
- cpu_wdata  in  DWIDTH  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DWIDTH  read data, valid while cpu_ack=1.
- dbg_req, dbg_we, dbg_adr, dbg_wdata  in  1/1/AWIDTH/DWIDTH  DBG request, same rules as CPU.
- dbg_ack  out  1  one-cycle completion pulse for DBG.
- dbg_rdata  out  DWIDTH  DBG read data, valid while dbg_ack=1.
- mem_cs  out  1  memory select.
- mem_we  out  1  memory write enable.
- mem_adr  out  AWIDTH  memory address.
- mem_wdata  out  DWIDTH  memory write data.
- mem_rdata  in  DWIDTH  memory read data.
- busy  out  1  1 when not IDLE.
- grant_dbg  out  1  1 when the current or last grant went to DBG.

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values: state=IDLE, all acks=0, mem_cs=0, mem_we=0, mem_adr=0, mem_wdata=0, cpu_rdata=0, dbg_rdata=0, busy=0, last_grant=DBG (grant_dbg=1), wait counter=0.
- All outputs are registered.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - At the clock edge, sample both requests.
  - None asserted: stay in IDLE.
  - One asserted: grant it.
  - Both asserted: grant the requester not in last_grant (round-robin), so the CPU wins the first tie after reset.
  - On grant: latch we/adr/wdata of the winner into mem_*, set mem_cs=1, set counter=WAIT_CYCLES-1, update last_grant, go to ACCESS.
- ACCESS:
  - mem_cs=1; mem_we=latched we for the whole state.
  - Counter decrements each cycle.
  - When counter==0:
    - on a read, capture mem_rdata into the winner's rdata register;
    - drop mem_cs and mem_we;
    - assert the winner's ack;
    - go to ACK.
  - ACCESS lasts exactly WAIT_CYCLES cycles.
- ACK:
  - The winner's ack is 1 for exactly this cycle.
  - Unconditionally go to IDLE.
  - A requester drops req in the cycle after ack; a req still high in IDLE is treated as a new request.
- Latency: req first high in IDLE cycle t gives mem_cs in cycles t+1..t+WAIT_CYCLES and ack in cycle t+WAIT_CYCLES+1.
- Throughput: one access per WAIT_CYCLES+2 cycles.
- Writes leave the rdata registers unchanged.
- The losing requester's ack stays 0; its req must remain asserted, and it is served in the next IDLE.
- No starvation: with both requests continuously asserted, grants strictly alternate.
- Request fields changing while a grant is in progress: ignored, since fields were latched at grant.
- Reset during ACCESS or ACK:
  - Return to IDLE next cycle with mem_cs=0 and no ack.
  - The transaction is dropped and the requester must reissue.
  - A write may or may not have reached memory.
- busy=1 in ACCESS and ACK.

Decomposition:
- Package mips_mem_arb_pkg holds:
  - arb_state_t enum {IDLE, ACCESS, ACK} (logic [1:0]);
  - grant_t enum {GRANT_CPU, GRANT_DBG}.
- Sub-module rr_arbiter2:
  - combinational two-way round-robin pick from (cpu_req, dbg_req, last_grant);
  - outputs grant_t plus a valid bit.
- last_grant register and the FSM live in the top block.

Test Plan:
1. WAIT_CYCLES=2. cpu_req read adr 0x10, memory model returns 0xA5, req raised in cycle 1 -> mem_cs=1 with mem_adr=0x10 in cycles 2-3, cpu_ack=1 with cpu_rdata=0xA5 in cycle 4 only, dbg_ack stays 0.
2. dbg write adr 0x3F data 0x5C -> mem_we=1 in both ACCESS cycles, memory[0x3F]=0x5C, dbg_ack pulse, cpu_rdata and dbg_rdata unchanged.
3. Both requesters held high from reset release:
   - grants in order CPU, DBG, CPU, DBG;
   - acks spaced exactly 4 cycles apart (WAIT_CYCLES+2);
   - grant_dbg toggles 0, 1, 0, 1.
4. Reset asserted in the second ACCESS cycle of a CPU write -> next cycle IDLE, mem_cs=0, no cpu_ack; reissued req completes normally.
5. WAIT_CYCLES=1, back-to-back CPU reads 0x00 then 0x01 (req dropped one cycle after ack) -> second ack exactly 3 cycles after the first, with the correct data.
6. dbg_adr changed from 0x20 to 0x21 mid-ACCESS -> mem_adr stays 0x20 through completion.
